// File: rtl/display_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
// Holds digit count, saturation limits and the sequencer state enum.
package display_pkg;

  localparam int          BCD_DIGITS = 6;
  localparam int          BCD_MAX    = 999999;
  localparam logic [23:0] BCD_SAT    = 24'h999999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 when the nibble is 5 or more.
// Ports: i_d (4-bit digit in), o_d (4-bit adjusted digit out).
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin2bcd_sequencer.sv
// Iterative binary-to-BCD converter, one input bit per clock, saturating.
// Ports: i_clk, i_reset, i_valid/o_ready, i_bin, o_num, o_done, o_overflow.
module bin2bcd_sequencer
  import display_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_bin,
  output logic             o_ready,
  output logic [23:0]      o_num,
  output logic             o_done,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [23:0]      r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_flag;

  logic [23:0]      w_adj;
  logic [24:0]      w_shift;
  logic             w_last;
  logic             w_ovf;
  logic             w_sat;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .i_d (r_scr[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  assign w_shift = {w_adj, r_bin[WIDTH-1]};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf   = 33'(i_bin) > 33'(BCD_MAX);
  // A carry out of digit 5 can only come from an overflowing value,
  // so it simply joins the saturation condition.
  assign w_sat   = r_flag | w_shift[24];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_flag     <= 1'b0;
      o_ready    <= 1'b1;
      o_num      <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_valid && o_ready) begin
            r_bin   <= i_bin;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_flag  <= w_ovf;
            o_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr <= w_shift[23:0];
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            o_num      <= w_sat ? BCD_SAT : w_shift[23:0];
            o_overflow <= r_flag;
            o_done     <= 1'b1;
            o_ready    <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_sequencer.sv
// Self-checking bench for bin2bcd_sequencer (WIDTH=20).
// Compares against a decimal-arithmetic reference model.
module tb_bin2bcd_sequencer;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic [W-1:0]  i_bin;
  logic          o_ready;
  logic [23:0]   o_num;
  logic          o_done;
  logic          o_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] prev_num;
  logic        prev_ovf;

  bin2bcd_sequencer #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_bin      (i_bin),
    .o_ready    (o_ready),
    .o_num      (o_num),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bcd_of(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    if (v > 999999) return 24'h999999;
    x = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with cycle-exact checks; gs>0 injects a
  // one-cycle i_valid=555 pulse after shift step gs.
  task automatic convert(input int unsigned v, input int gs);
    logic [23:0] exp;
    logic        ovf;
    exp = bcd_of(v);
    ovf = (v > 999999);
    chk("ready_before", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_bin   = W'(v);
    tick();
    i_valid = 1'b0;
    i_bin   = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W) begin
        chk("busy_ready", 32'(o_ready), 32'd0);
        chk("busy_done", 32'(o_done), 32'd0);
        chk("hold_num", 32'(o_num), 32'(prev_num));
        chk("hold_ovf", 32'(o_overflow), 32'(prev_ovf));
        if (k == gs) begin
          i_valid = 1'b1;
          i_bin   = W'(555);
        end else begin
          i_valid = 1'b0;
        end
      end else begin
        chk("done", 32'(o_done), 32'd1);
        chk("num", 32'(o_num), 32'(exp));
        chk("ovf", 32'(o_overflow), 32'(ovf));
        chk("ready_done", 32'(o_ready), 32'd1);
      end
    end
    i_valid  = 1'b0;
    prev_num = exp;
    prev_ovf = ovf;
    tick();
    chk("done_1cyc", 32'(o_done), 32'd0);
    chk("num_keep", 32'(o_num), 32'(exp));
  endtask

  initial begin
    int unsigned v;
    int first, second, nd, seen;
    logic [23:0] q [$];

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_bin   = '0;
    prev_num = '0;
    prev_ovf = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_num", 32'(o_num), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    i_reset = 1'b0;
    tick();

    convert(0, 0);
    convert(123456, 0);
    convert(999999, 0);
    convert(1048575, 0);
    convert(1000000, 0);

    for (int i = 0; i < 8; i++) begin
      if (i[0]) v = $urandom_range(999999, 0);
      else      v = $urandom_range(1048575, 0);
      convert(v, 0);
    end

    // i_valid pulse while busy must be ignored
    convert(321, 5);
    convert($urandom_range(1048575, 0), 19);
    tick();
    chk("no_extra_done", 32'(o_done), 32'd0);

    // Back-to-back with i_valid held
    q = {bcd_of(7), bcd_of(42)};
    i_valid = 1'b1;
    i_bin   = W'(7);
    tick();
    i_bin = W'(42);
    first = -1;
    second = -1;
    nd = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (o_done) begin
        nd++;
        if (nd == 1) first = c;
        else if (nd == 2) second = c;
        if (q.size() > 0) chk("b2b_num", 32'(o_num), 32'(q.pop_front()));
        else chk("b2b_extra", 32'd1, 32'd0);
      end
      if (nd == 1 && c == first + 1) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    chk("b2b_count", 32'(nd), 32'd2);
    chk("b2b_first", 32'(first), 32'd20);
    chk("b2b_gap", 32'(second - first), 32'd21);
    prev_num = bcd_of(42);
    prev_ovf = 1'b0;
    tick();

    // Reset at shift step 10 aborts the conversion
    i_valid = 1'b1;
    i_bin   = W'(654321);
    tick();
    i_valid = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    i_reset = 1'b1;
    tick();
    chk("abort_num", 32'(o_num), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_ovf", 32'(o_overflow), 32'd0);
    i_reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    prev_num = '0;
    prev_ovf = 1'b0;

    // Reset and i_valid together: nothing accepted
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_bin   = W'(777);
    tick();
    i_reset = 1'b0;
    i_valid = 1'b0;
    chk("rv_ready", 32'(o_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (o_done) seen++;
    end
    chk("rv_no_done", 32'(seen), 32'd0);
    chk("rv_num", 32'(o_num), 32'd0);

    convert($urandom_range(999999, 0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
